hazard_scoreboard: RTL

Parametrised hazard and forwarding unit for the five-stage MIPS pipeline; it replaces purely combinational address-compare forwarding with a per-stage scoreboard.
- The scoreboard tracks each in-flight destination register and its remaining Tnew.
- It issues the D-stage stall from the Tuse/Tnew rule and selects forwarded operands for both D-stage and E-stage consumers.
- It sits beside the D/E/M/W pipeline registers and is driven by the D-stage decoder.

---
 rtl/hazard_scoreboard.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard detection and operand forwarding for a five-stage MIPS pipeline.
//   Each in-flight destination register is tracked with its remaining Tnew.
//   The D-stage stall comes from comparing that Tnew against the consumer's
//   Tuse. Forwarded operands are selected for both D-stage and E-stage readers.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   d_issue_valid D instruction writes a register
//   d_a3          D destination register
//   d_tnew        cycles until the result exists, counted from E
//   d_rvalid      per-port D read enable
//   d_raddr       D read addresses, port i at [i*AW +: AW]
//   d_rtuse       cycles from D until each operand is needed
//   d_rf_data     GRF read data for the D operands
//   e_rf_data     operands held in the D/E register
//   st_wd         per-stage result data (E, M, W), valid when that Tnew is 0
//   stall         freeze F/D and insert a bubble into E
//   fd_data       forwarded D operands
//   fe_data       forwarded E operands
//   stall_cnt     stalled-cycle counter
//
// Build option
//   HZ_STALL_CNT_EN  when defined, stall_cnt counts stalled cycles and
//                    saturates at all-ones. Otherwise stall_cnt is tied to 0.

module hazard_scoreboard #(
    parameter int NUM_RD = 2,
    parameter int NUM_ST = 3,
    parameter int AW     = 5,
    parameter int DW     = 32,
    parameter int TW     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_issue_valid,
    input  logic [AW-1:0]        d_a3,
    input  logic [TW-1:0]        d_tnew,
    input  logic [NUM_RD-1:0]    d_rvalid,
    input  logic [NUM_RD*AW-1:0] d_raddr,
    input  logic [NUM_RD*TW-1:0] d_rtuse,
    input  logic [NUM_RD*DW-1:0] d_rf_data,
    input  logic [NUM_RD*DW-1:0] e_rf_data,
    input  logic [NUM_ST*DW-1:0] st_wd,
    output logic                 stall,
    output logic [NUM_RD*DW-1:0] fd_data,
    output logic [NUM_RD*DW-1:0] fe_data,
    output logic [31:0]          stall_cnt
);

    // Stage index 0 is E, the youngest. Higher indices are older.
    logic [NUM_ST-1:0] ent_valid;
    logic [AW-1:0]     ent_a3   [NUM_ST];
    logic [TW-1:0]     ent_tnew [NUM_ST];

    // Read addresses of the instruction now in E, used for E-stage forwarding.
    logic [NUM_RD-1:0] e_rvalid;
    logic [AW-1:0]     e_raddr  [NUM_RD];

    always_comb begin
        logic          d_hit;
        logic [TW-1:0] d_hit_tnew;
        logic [DW-1:0] d_hit_wd;
        logic          e_hit;
        logic [TW-1:0] e_hit_tnew;
        logic [DW-1:0] e_hit_wd;
        logic [AW-1:0] raddr;

        stall      = 1'b0;
        fd_data    = d_rf_data;
        fe_data    = e_rf_data;
        d_hit      = 1'b0;
        d_hit_tnew = '0;
        d_hit_wd   = '0;
        e_hit      = 1'b0;
        e_hit_tnew = '0;
        e_hit_wd   = '0;
        raddr      = '0;

        for (int i = 0; i < NUM_RD; i++) begin
            // D port: scan from oldest to youngest so the youngest match wins,
            // even when it is not ready and an older one is.
            raddr      = d_raddr[i*AW +: AW];
            d_hit      = 1'b0;
            d_hit_tnew = '0;
            d_hit_wd   = '0;
            for (int k = NUM_ST - 1; k >= 0; k--) begin
                if (ent_valid[k] && (ent_a3[k] == raddr)) begin
                    d_hit      = 1'b1;
                    d_hit_tnew = ent_tnew[k];
                    d_hit_wd   = st_wd[k*DW +: DW];
                end
            end
            if (d_rvalid[i] && (raddr != '0) && d_hit &&
                (d_hit_tnew > d_rtuse[i*TW +: TW]))
                stall = 1'b1;
            if (d_hit && (d_hit_tnew == '0))
                fd_data[i*DW +: DW] = d_hit_wd;

            // E port: the E entry is the consumer's own slot, so only M and
            // later can supply it.
            e_hit      = 1'b0;
            e_hit_tnew = '0;
            e_hit_wd   = '0;
            for (int k = NUM_ST - 1; k >= 1; k--) begin
                if (ent_valid[k] && (ent_a3[k] == e_raddr[i])) begin
                    e_hit      = 1'b1;
                    e_hit_tnew = ent_tnew[k];
                    e_hit_wd   = st_wd[k*DW +: DW];
                end
            end
            if (e_rvalid[i] && (e_raddr[i] != '0) && e_hit && (e_hit_tnew == '0))
                fe_data[i*DW +: DW] = e_hit_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            for (int k = 0; k < NUM_ST; k++) begin
                ent_a3[k]   <= '0;
                ent_tnew[k] <= '0;
            end
            e_rvalid <= '0;
            for (int i = 0; i < NUM_RD; i++)
                e_raddr[i] <= '0;
        end else begin
            // A stalled D instruction enters E as a bubble and is re-presented.
            ent_valid[0] <= d_issue_valid && (d_a3 != '0) && !stall;
            ent_a3[0]    <= d_a3;
            ent_tnew[0]  <= d_tnew;
            for (int k = 1; k < NUM_ST; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_a3[k]    <= ent_a3[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
            end
            for (int i = 0; i < NUM_RD; i++) begin
                e_rvalid[i] <= d_rvalid[i] && !stall;
                e_raddr[i]  <= stall ? '0 : d_raddr[i*AW +: AW];
            end
        end
    end

`ifdef HZ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule
